// File: rtl/sdr_seq_pkg.sv
// Shared types and helpers for the SDRAM batch sequencer.
// Status word layout and byte/word conversion live here.
package sdr_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CMP,
    S_RES,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } seq_state_e;

  localparam int STAT_OK_BIT    = 0;
  localparam int STAT_TMO_BIT   = 1;
  localparam int STAT_BATCH_LSB = 16;
  localparam int WORD_SHIFT     = 2;

  function automatic logic [31:0] words_to_bytes(
    input logic [29:0] w
  );
    return 32'(w) << WORD_SHIFT;
  endfunction

  function automatic logic [29:0] batch_len(
    input logic [29:0] rem,
    input logic [29:0] max_w
  );
    return (rem < max_w) ? rem : max_w;
  endfunction

endpackage

// File: rtl/sdr_batch_sequencer_if.sv
// SDRAM bridge and intersector bundle for the batch sequencer.
// master = sequencer side, slave = bridge/intersector side.
interface sdr_batch_sequencer_if #(
  parameter int DATA_W = 2048
);
  logic [31:0]       sdr_baseaddr;
  logic [29:0]       sdr_nelems;
  logic              sdr_readstart;
  logic              sdr_readend;
  logic [DATA_W-1:0] sdr_readdata;
  logic              sdr_writestart;
  logic              sdr_writeend;
  logic [DATA_W-1:0] sdr_writedata;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_data;
  logic              cmp_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;

  modport master (
    output sdr_baseaddr, sdr_nelems,
    output sdr_readstart, sdr_writestart,
    output sdr_writedata,
    output cmp_valid, cmp_data, res_ready,
    input  sdr_readend, sdr_readdata,
    input  sdr_writeend,
    input  cmp_ready, res_valid, res_data
  );

  modport slave (
    input  sdr_baseaddr, sdr_nelems,
    input  sdr_readstart, sdr_writestart,
    input  sdr_writedata,
    input  cmp_valid, cmp_data, res_ready,
    output sdr_readend, sdr_readdata,
    output sdr_writeend,
    output cmp_ready, res_valid, res_data
  );
endinterface

// File: rtl/sdr_seq_addr_gen.sv
// Job pointers, remaining-word count, batch length and batch counter.
// load latches a new job; adv retires the current batch.
module sdr_seq_addr_gen
  import sdr_seq_pkg::*;
#(
  parameter int BATCH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] job_rdaddr,
  input  logic [31:0] job_wraddr,
  input  logic [29:0] job_nwords,
  output logic [31:0] rd_ptr,
  output logic [31:0] wr_ptr,
  output logic [29:0] cur,
  output logic        last,
  output logic [15:0] batches
);

  localparam logic [29:0] MAXW = 30'(BATCH_WORDS);

  logic [29:0] rem_q;
  logic [29:0] rem_nx;

  assign rem_nx = rem_q - cur;
  assign last   = (rem_q == cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rem_q   <= '0;
      cur     <= '0;
      batches <= '0;
    end else if (load) begin
      rd_ptr  <= job_rdaddr;
      wr_ptr  <= job_wraddr;
      rem_q   <= job_nwords;
      cur     <= batch_len(job_nwords, MAXW);
      batches <= '0;
    end else if (adv) begin
      rd_ptr <= rd_ptr + words_to_bytes(cur);
      wr_ptr <= wr_ptr + words_to_bytes(cur);
      rem_q  <= rem_nx;
      cur    <= batch_len(rem_nx, MAXW);
      if (batches != 16'hFFFF)
        batches <= batches + 16'd1;
    end
  end

endmodule

// File: rtl/sdr_batch_sequencer.sv
// Ray-tracing job sequencer: read batch, intersect, write back, repeat.
// Optional watchdog enabled by defining SDR_SEQ_WATCHDOG_EN.
module sdr_batch_sequencer
  import sdr_seq_pkg::*;
#(
  parameter int DATA_W      = 2048,
  parameter int BATCH_WORDS = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        sdr_clk,
  input  logic        sdr_reset,
  input  logic        start_rt,
  input  logic [31:0] job_rdaddr,
  input  logic [31:0] job_wraddr,
  input  logic [29:0] job_nwords,
  output logic        end_rt,
  output logic [31:0] end_rtstat,
  sdr_batch_sequencer_if.master bus
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_buf;
  logic              tmo_q;
  logic              load, adv, last;
  logic              cap_rd, cap_res;
  logic              wd_hit, tmo_set;
  logic [31:0]       rd_ptr, wr_ptr;
  logic [29:0]       cur;
  logic [15:0]       batches;

  sdr_seq_addr_gen #(
    .BATCH_WORDS(BATCH_WORDS)
  ) u_addr (
    .clk       (sdr_clk),
    .rst       (sdr_reset),
    .load      (load),
    .adv       (adv),
    .job_rdaddr(job_rdaddr),
    .job_wraddr(job_wraddr),
    .job_nwords(job_nwords),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr),
    .cur       (cur),
    .last      (last),
    .batches   (batches)
  );

  always_ff @(posedge sdr_clk) begin
    if (sdr_reset) begin
      state_q  <= S_IDLE;
      data_buf <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_rd)
        data_buf <= bus.sdr_readdata;
      else if (cap_res)
        data_buf <= bus.res_data;
      if (load)
        tmo_q <= 1'b0;
      else if (tmo_set)
        tmo_q <= 1'b1;
    end
  end

`ifdef SDR_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] wd_cnt;
  logic          wd_run;

  assign wd_run = state_q inside {S_RD_WAIT, S_CMP, S_RES, S_WR_WAIT};
  assign wd_hit = wd_run && (wd_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge sdr_clk) begin
    if (sdr_reset)
      wd_cnt <= '0;
    else if (!wd_run || state_d != state_q)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + CW'(1);
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    load               = 1'b0;
    adv                = 1'b0;
    cap_rd             = 1'b0;
    cap_res            = 1'b0;
    tmo_set            = 1'b0;
    end_rt             = 1'b0;
    end_rtstat         = '0;
    bus.sdr_baseaddr   = '0;
    bus.sdr_nelems     = '0;
    bus.sdr_readstart  = 1'b0;
    bus.sdr_writestart = 1'b0;
    bus.sdr_writedata  = '0;
    bus.cmp_valid      = 1'b0;
    bus.cmp_data       = '0;
    bus.res_ready      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_rt) begin
          load    = 1'b1;
          state_d = (job_nwords == 30'd0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ, S_RD_WAIT: begin
        bus.sdr_baseaddr  = rd_ptr;
        bus.sdr_nelems    = cur;
        bus.sdr_readstart = (state_q == S_RD_REQ);
        if (state_q == S_RD_REQ) begin
          state_d = S_RD_WAIT;
        end else if (bus.sdr_readend) begin
          cap_rd  = 1'b1;
          state_d = S_CMP;
        end else if (wd_hit) begin
          tmo_set = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CMP: begin
        bus.cmp_valid = 1'b1;
        bus.cmp_data  = data_buf;
        if (bus.cmp_ready) begin
          state_d = S_RES;
        end else if (wd_hit) begin
          tmo_set = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RES: begin
        bus.res_ready = 1'b1;
        if (bus.res_valid) begin
          cap_res = 1'b1;
          state_d = S_WR_REQ;
        end else if (wd_hit) begin
          tmo_set = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WR_REQ, S_WR_WAIT: begin
        bus.sdr_baseaddr   = wr_ptr;
        bus.sdr_nelems     = cur;
        bus.sdr_writedata  = data_buf;
        bus.sdr_writestart = (state_q == S_WR_REQ);
        if (state_q == S_WR_REQ) begin
          state_d = S_WR_WAIT;
        end else if (bus.sdr_writeend) begin
          adv     = 1'b1;
          state_d = last ? S_DONE : S_RD_REQ;
        end else if (wd_hit) begin
          tmo_set = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        end_rt                               = 1'b1;
        end_rtstat[STAT_OK_BIT]              = ~tmo_q;
        end_rtstat[STAT_TMO_BIT]             = tmo_q;
        end_rtstat[STAT_BATCH_LSB +: 16]     = batches;
        if (!start_rt)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdr_batch_sequencer.sv
// Directed testbench for sdr_batch_sequencer with a bridge/intersector responder.
// Watchdog scenario runs when SDR_SEQ_WATCHDOG_EN is defined.
module tb_sdr_batch_sequencer;
  localparam int DW = 2048;
  localparam int NW = DW / 32;

  logic        sdr_clk = 1'b0;
  logic        sdr_reset = 1'b1;
  logic        start_rt = 1'b0;
  logic [31:0] job_rdaddr = '0;
  logic [31:0] job_wraddr = '0;
  logic [29:0] job_nwords = '0;
  logic        end_rt;
  logic [31:0] end_rtstat;

  sdr_batch_sequencer_if #(.DATA_W(DW)) bus ();

  sdr_batch_sequencer #(
    .DATA_W     (DW),
    .BATCH_WORDS(64),
    .TIMEOUT_CYC(100)
  ) dut (
    .sdr_clk   (sdr_clk),
    .sdr_reset (sdr_reset),
    .start_rt  (start_rt),
    .job_rdaddr(job_rdaddr),
    .job_wraddr(job_wraddr),
    .job_nwords(job_nwords),
    .end_rt    (end_rt),
    .end_rtstat(end_rtstat),
    .bus       (bus)
  );

  always #5 sdr_clk = ~sdr_clk;

  int vecs = 0;
  int errs = 0;

  // responder controls and logs
  int rd_lat = 2;
  int cmp_hold = 0;
  bit early_res = 1'b0;
  logic [31:0] rd_addr_q[$];
  logic [29:0] rd_n_q[$];
  logic [31:0] wr_addr_q[$];
  logic [29:0] wr_n_q[$];
  logic [31:0] wr_w0_q[$];
  logic [31:0] wr_wl_q[$];
  int rs_run = 0, rs_max = 0, ws_run = 0, ws_max = 0;
  int cmp_cyc = 0, cmp_len = 0, cmp_unstable = 0;
  logic [DW-1:0] cmp_prev;

  initial begin
    bit in_rd, in_wr;
    int rd_wait, wr_wait;
    in_rd = 0; in_wr = 0; rd_wait = 0; wr_wait = 0;
    bus.sdr_readend = 0; bus.sdr_writeend = 0;
    bus.sdr_readdata = '0; bus.cmp_ready = 0;
    bus.res_valid = 0; bus.res_data = '0;
    cmp_prev = '0;
    forever begin
      @(negedge sdr_clk);
      bus.sdr_readend = 0;
      bus.sdr_writeend = 0;
      bus.res_valid = 0;
      bus.cmp_ready = 0;
      if (sdr_reset) begin
        in_rd = 0;
        in_wr = 0;
      end
      if (in_rd) begin
        rd_wait++;
        if (rd_lat != 0 && rd_wait >= rd_lat) begin
          bus.sdr_readend = 1;
          bus.sdr_readdata = {NW{bus.sdr_baseaddr}};
          in_rd = 0;
        end
      end
      if (bus.sdr_readstart) begin
        rd_addr_q.push_back(bus.sdr_baseaddr);
        rd_n_q.push_back(bus.sdr_nelems);
        in_rd = 1;
        rd_wait = 0;
        rs_run++;
      end else rs_run = 0;
      if (rs_run > rs_max) rs_max = rs_run;
      if (in_wr) begin
        wr_wait++;
        if (wr_wait >= 2) begin
          bus.sdr_writeend = 1;
          in_wr = 0;
        end
      end
      if (bus.sdr_writestart) begin
        wr_addr_q.push_back(bus.sdr_baseaddr);
        wr_n_q.push_back(bus.sdr_nelems);
        wr_w0_q.push_back(bus.sdr_writedata[31:0]);
        wr_wl_q.push_back(bus.sdr_writedata[DW-1 -: 32]);
        in_wr = 1;
        wr_wait = 0;
        ws_run++;
      end else ws_run = 0;
      if (ws_run > ws_max) ws_max = ws_run;
      if (bus.cmp_valid) begin
        cmp_cyc++;
        if (cmp_cyc > 1 && bus.cmp_data !== cmp_prev) cmp_unstable++;
        cmp_prev = bus.cmp_data;
        if (early_res && cmp_cyc == 5) begin
          bus.res_valid = 1;
          bus.res_data = {NW{32'hDEAD_BEEF}};
        end
        if (cmp_cyc > cmp_hold) begin
          bus.cmp_ready = 1;
          bus.res_data = ~bus.cmp_data;
          cmp_len = cmp_cyc;
        end
      end else cmp_cyc = 0;
      if (bus.res_ready) bus.res_valid = 1;
    end
  end

  task automatic run_job(
    input  logic [31:0] ra,
    input  logic [31:0] wa,
    input  logic [29:0] n,
    output bit          done,
    output logic [31:0] stat,
    output int          cyc,
    output logic        end_after,
    output logic [31:0] stat_after
  );
    @(negedge sdr_clk);
    job_rdaddr = ra;
    job_wraddr = wa;
    job_nwords = n;
    start_rt = 1;
    done = 0;
    stat = '0;
    cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sdr_clk);
      cyc++;
      if (end_rt) begin
        done = 1;
        break;
      end
    end
    stat = end_rtstat;
    start_rt = 0;
    @(negedge sdr_clk);
    end_after = end_rt;
    stat_after = end_rtstat;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sdr_clk);
    vecs++;
    if ({end_rt, end_rtstat, bus.sdr_baseaddr, bus.sdr_nelems,
         bus.sdr_readstart, bus.sdr_writestart, bus.cmp_valid,
         bus.res_ready, |bus.cmp_data, |bus.sdr_writedata} !== '0) begin
      errs++;
      $display("FAIL reset_outputs end_rt=%b stat=%h base=%h n=%h rs=%b ws=%b cv=%b rr=%b required all 0",
               end_rt, end_rtstat, bus.sdr_baseaddr, bus.sdr_nelems,
               bus.sdr_readstart, bus.sdr_writestart, bus.cmp_valid, bus.res_ready);
    end
    sdr_reset = 0;
  endtask

  task automatic test_single_batch;
    bit d; logic [31:0] st, sa; int c; logic ea;
    int r0 = rd_addr_q.size();
    int w0 = wr_addr_q.size();
    run_job(32'h1000, 32'h8000, 30'd64, d, st, c, ea, sa);
    vecs++;
    if (!d || rd_addr_q.size() != r0 + 1 || wr_addr_q.size() != w0 + 1) begin
      errs++;
      $display("FAIL single_done done=%b reads=%0d writes=%0d required 1/1/1", d,
               rd_addr_q.size() - r0, wr_addr_q.size() - w0);
      return;
    end
    vecs++;
    if (rd_addr_q[r0] !== 32'h1000 || rd_n_q[r0] !== 30'd64) begin
      errs++;
      $display("FAIL single_read got %h/%0d required 00001000/64", rd_addr_q[r0], rd_n_q[r0]);
    end
    vecs++;
    if (wr_addr_q[w0] !== 32'h8000 || wr_n_q[w0] !== 30'd64) begin
      errs++;
      $display("FAIL single_write got %h/%0d required 00008000/64", wr_addr_q[w0], wr_n_q[w0]);
    end
    vecs++;
    if (wr_w0_q[w0] !== 32'hFFFF_EFFF || wr_wl_q[w0] !== 32'hFFFF_EFFF) begin
      errs++;
      $display("FAIL single_wdata got %h/%h required ffffefff", wr_w0_q[w0], wr_wl_q[w0]);
    end
    vecs++;
    if (st !== 32'h0001_0001) begin
      errs++;
      $display("FAIL single_stat got %h required 00010001", st);
    end
    vecs++;
    if (ea !== 1'b0 || sa !== 32'h0) begin
      errs++;
      $display("FAIL single_release end_rt=%b stat=%h required 0/0", ea, sa);
    end
  endtask

  task automatic test_multi_batch;
    bit d; logic [31:0] st, sa; int c; logic ea;
    logic [31:0] ea_r[3];
    logic [29:0] en[3];
    int r0 = rd_addr_q.size();
    int w0 = wr_addr_q.size();
    ea_r[0] = 32'h1000; ea_r[1] = 32'h1100; ea_r[2] = 32'h1200;
    en[0] = 30'd64; en[1] = 30'd64; en[2] = 30'd22;
    run_job(32'h1000, 32'h8000, 30'd150, d, st, c, ea, sa);
    vecs++;
    if (!d || rd_addr_q.size() != r0 + 3 || wr_addr_q.size() != w0 + 3) begin
      errs++;
      $display("FAIL multi_done done=%b reads=%0d writes=%0d required 1/3/3", d,
               rd_addr_q.size() - r0, wr_addr_q.size() - w0);
      return;
    end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (rd_addr_q[r0+i] !== ea_r[i] || rd_n_q[r0+i] !== en[i]) begin
        errs++;
        $display("FAIL multi_read%0d got %h/%0d required %h/%0d", i,
                 rd_addr_q[r0+i], rd_n_q[r0+i], ea_r[i], en[i]);
      end
      vecs++;
      if (wr_addr_q[w0+i] !== ea_r[i] + 32'h7000 || wr_n_q[w0+i] !== en[i]) begin
        errs++;
        $display("FAIL multi_write%0d got %h/%0d required %h/%0d", i,
                 wr_addr_q[w0+i], wr_n_q[w0+i], ea_r[i] + 32'h7000, en[i]);
      end
      vecs++;
      if (wr_w0_q[w0+i] !== ~ea_r[i]) begin
        errs++;
        $display("FAIL multi_wdata%0d got %h required %h", i, wr_w0_q[w0+i], ~ea_r[i]);
      end
    end
    vecs++;
    if (st !== 32'h0003_0001) begin
      errs++;
      $display("FAIL multi_stat got %h required 00030001", st);
    end
  endtask

  task automatic test_zero_words;
    bit d; logic [31:0] st, sa; int c; logic ea;
    int r0 = rd_addr_q.size();
    int w0 = wr_addr_q.size();
    run_job(32'h4000, 32'h5000, 30'd0, d, st, c, ea, sa);
    vecs++;
    if (!d || c != 1) begin
      errs++;
      $display("FAIL zero_latency done=%b cycles=%0d required 1/1", d, c);
    end
    vecs++;
    if (rd_addr_q.size() != r0 || wr_addr_q.size() != w0) begin
      errs++;
      $display("FAIL zero_no_xfer reads=%0d writes=%0d required 0/0",
               rd_addr_q.size() - r0, wr_addr_q.size() - w0);
    end
    vecs++;
    if (st !== 32'h0000_0001) begin
      errs++;
      $display("FAIL zero_stat got %h required 00000001", st);
    end
    vecs++;
    if (ea !== 1'b0 || sa !== 32'h0) begin
      errs++;
      $display("FAIL zero_release end_rt=%b stat=%h required 0/0", ea, sa);
    end
  endtask

  task automatic test_cmp_stall;
    bit d; logic [31:0] st, sa; int c; logic ea;
    int w0 = wr_addr_q.size();
    cmp_hold = 50;
    early_res = 1;
    cmp_unstable = 0;
    run_job(32'h2000, 32'hA000, 30'd64, d, st, c, ea, sa);
    cmp_hold = 0;
    early_res = 0;
    vecs++;
    if (!d || cmp_len != 51 || cmp_unstable != 0) begin
      errs++;
      $display("FAIL stall_cmp done=%b hold=%0d unstable=%0d required 1/51/0",
               d, cmp_len, cmp_unstable);
    end
    vecs++;
    if (wr_addr_q.size() != w0 + 1) begin
      errs++;
      $display("FAIL stall_writes got %0d required 1", wr_addr_q.size() - w0);
    end else if (wr_w0_q[w0] !== 32'hFFFF_DFFF || wr_wl_q[w0] !== 32'hFFFF_DFFF) begin
      errs++;
      $display("FAIL stall_wdata got %h/%h required ffffdfff", wr_w0_q[w0], wr_wl_q[w0]);
    end
    vecs++;
    if (st !== 32'h0001_0001) begin
      errs++;
      $display("FAIL stall_stat got %h required 00010001", st);
    end
  endtask

  task automatic test_reset_midjob;
    bit d, seen; logic [31:0] st, sa; int c; logic ea;
    int r0 = rd_addr_q.size();
    rd_lat = 0;
    @(negedge sdr_clk);
    job_rdaddr = 32'h3000;
    job_wraddr = 32'h9000;
    job_nwords = 30'd100;
    start_rt = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sdr_clk);
      if (bus.sdr_readstart) begin
        seen = 1;
        break;
      end
    end
    repeat (3) @(negedge sdr_clk);
    vecs++;
    if (!seen || bus.sdr_baseaddr !== 32'h3000) begin
      errs++;
      $display("FAIL midrst_wait seen=%b base=%h required 1/00003000", seen, bus.sdr_baseaddr);
    end
    sdr_reset = 1;
    start_rt = 0;
    @(negedge sdr_clk);
    vecs++;
    if ({end_rt, end_rtstat, bus.sdr_baseaddr, bus.sdr_nelems,
         bus.sdr_readstart, bus.sdr_writestart, bus.cmp_valid,
         bus.res_ready, |bus.cmp_data, |bus.sdr_writedata} !== '0) begin
      errs++;
      $display("FAIL midrst_outputs end_rt=%b stat=%h base=%h n=%h rs=%b required all 0",
               end_rt, end_rtstat, bus.sdr_baseaddr, bus.sdr_nelems, bus.sdr_readstart);
    end
    repeat (2) @(negedge sdr_clk);
    sdr_reset = 0;
    rd_lat = 2;
    vecs++;
    if (rd_addr_q.size() != r0 + 1) begin
      errs++;
      $display("FAIL midrst_no_reissue reads=%0d required 1", rd_addr_q.size() - r0);
    end
    run_job(32'h3000, 32'h9000, 30'd100, d, st, c, ea, sa);
    vecs++;
    if (!d || rd_addr_q.size() != r0 + 3) begin
      errs++;
      $display("FAIL midrst_restart done=%b reads=%0d required 1/3", d, rd_addr_q.size() - r0);
      return;
    end
    vecs++;
    if (rd_addr_q[r0+1] !== 32'h3000 || rd_n_q[r0+1] !== 30'd64 ||
        rd_addr_q[r0+2] !== 32'h3100 || rd_n_q[r0+2] !== 30'd36) begin
      errs++;
      $display("FAIL midrst_reads got %h/%0d %h/%0d required 00003000/64 00003100/36",
               rd_addr_q[r0+1], rd_n_q[r0+1], rd_addr_q[r0+2], rd_n_q[r0+2]);
    end
    vecs++;
    if (st !== 32'h0002_0001) begin
      errs++;
      $display("FAIL midrst_stat got %h required 00020001", st);
    end
  endtask

  task automatic test_pulses;
    vecs++;
    if (rs_max != 1 || ws_max != 1) begin
      errs++;
      $display("FAIL pulse_width readstart=%0d writestart=%0d required 1/1", rs_max, ws_max);
    end
  endtask

`ifdef SDR_SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    bit seen, d;
    int c;
    logic [31:0] st;
    rd_lat = 0;
    @(negedge sdr_clk);
    job_rdaddr = 32'h6000;
    job_wraddr = 32'h7000;
    job_nwords = 30'd10;
    start_rt = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sdr_clk);
      if (bus.sdr_readstart) begin
        seen = 1;
        break;
      end
    end
    d = 0;
    c = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sdr_clk);
      c++;
      if (end_rt) begin
        d = 1;
        break;
      end
    end
    st = end_rtstat;
    vecs++;
    if (!seen || !d || c != 101) begin
      errs++;
      $display("FAIL wdog_latency seen=%b done=%b cycles=%0d required 1/1/101", seen, d, c);
    end
    vecs++;
    if (st !== 32'h0000_0002) begin
      errs++;
      $display("FAIL wdog_stat got %h required 00000002", st);
    end
    start_rt = 0;
    @(negedge sdr_clk);
    vecs++;
    if (end_rt !== 1'b0) begin
      errs++;
      $display("FAIL wdog_release end_rt=%b required 0", end_rt);
    end
    rd_lat = 2;
  endtask
`endif

  initial begin
    test_reset();
    test_single_batch();
    test_multi_batch();
    test_zero_words();
    test_cmp_stall();
    test_reset_midjob();
`ifdef SDR_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    test_pulses();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
